// File: rtl/seq_pattern_pkg.sv
// seq_pattern_pkg: shared state encoding, default pattern and counter-width helper
package seq_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [4:0] DEF_PAT = 5'b11101;

    // Width needed to hold 0..n-1, at least one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_pattern_shreg.sv
// seq_pattern_shreg: W-bit parallel-load shift register, MSB out first
// Ports: clk, rst_n (async active-low), clear/load/shift controls (clear > load > shift),
//        d parallel load value, msb = current bit, nxt = bit presented after the next shift.
module seq_pattern_shreg
    import seq_pattern_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         msb,
    output logic         nxt
);

    logic [W-1:0] q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            q <= '0;
        else
            q <= clear ? '0 : load ? d : shift ? {q[W-2:0], 1'b0} : q;

    assign msb = q[W-1];
    assign nxt = q[W-2];

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: repeats a fixed or loaded bit pattern MSB-first on a serial line
// Ports: clk, rst_n (async active-low); start/abort requests; use_custom, pat_in, rep_cnt
//        latched at start; out_seq/out_valid serial stream; busy while not IDLE; done pulse.
module seq_pattern_tx
    import seq_pattern_pkg::*;
#(
    parameter int               PAT_W       = 5,
    parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(DEF_PAT),
    parameter int               GAP_CYC     = 2,
    parameter int               REP_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             use_custom,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [REP_W-1:0] rep_cnt,
    output logic             out_seq,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int BW = cnt_w(PAT_W);
    localparam int GW = cnt_w(GAP_CYC);

    state_t           state, state_d;
    logic [BW-1:0]    bit_idx, bit_d;
    logic [REP_W-1:0] reps_left, reps_d;
    logic [GW-1:0]    gap_cnt, gap_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             seq_d, valid_d, busy_d, done_d;
    logic             sh_load, sh_shift, sh_clear, sh_msb, sh_nxt;

    // The shift register MSB is always the bit currently on out_seq, so the
    // registered output for the next cycle is either its next bit or a fresh MSB.
    seq_pattern_shreg #(.W(PAT_W)) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (sh_clear),
        .load  (sh_load),
        .shift (sh_shift),
        .d     (pat_d),
        .msb   (sh_msb),
        .nxt   (sh_nxt)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            bit_idx   <= '0;
            reps_left <= '0;
            gap_cnt   <= '0;
            pat_q     <= '0;
            out_seq   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            bit_idx   <= bit_d;
            reps_left <= reps_d;
            gap_cnt   <= gap_d;
            pat_q     <= pat_d;
            out_seq   <= seq_d;
            out_valid <= valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end

    always_comb begin
        state_d  = state;
        bit_d    = bit_idx;
        reps_d   = reps_left;
        gap_d    = gap_cnt;
        pat_d    = pat_q;
        seq_d    = 1'b0;
        valid_d  = 1'b0;
        busy_d   = 1'b1;
        done_d   = 1'b0;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_clear = 1'b0;
        case (state)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    pat_d   = use_custom ? pat_in : DEF_PATTERN;
                    sh_load = 1'b1;
                    reps_d  = (rep_cnt == '0) ? REP_W'(1) : rep_cnt;
                    bit_d   = BW'(PAT_W - 1);
                    state_d = SEND;
                    seq_d   = pat_d[PAT_W-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SEND: begin
                if (bit_idx != '0) begin
                    bit_d    = bit_idx - BW'(1);
                    sh_shift = 1'b1;
                    seq_d    = sh_nxt;
                    valid_d  = 1'b1;
                end else if (reps_left > REP_W'(1)) begin
                    reps_d  = reps_left - REP_W'(1);
                    sh_load = 1'b1;
                    bit_d   = BW'(PAT_W - 1);
                    if (GAP_CYC > 0) begin
                        state_d = GAP;
                        gap_d   = GW'(GAP_CYC - 1);
                    end else begin
                        seq_d   = pat_q[PAT_W-1];
                        valid_d = 1'b1;
                    end
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_d = SEND;
                    seq_d   = sh_msb;
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_cnt - GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // Abort overrides every transition, including the final bit and DONE.
        if (abort && state != IDLE) begin
            state_d  = IDLE;
            bit_d    = '0;
            reps_d   = '0;
            gap_d    = '0;
            seq_d    = 1'b0;
            valid_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            sh_load  = 1'b0;
            sh_shift = 1'b0;
            sh_clear = 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: scoreboard bench for seq_pattern_tx with gapped and back-to-back instances
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start2 = 1'b0, abort2 = 1'b0, start0 = 1'b0, abort0 = 1'b0;
    logic       use_custom = 1'b0;
    logic [4:0] pat_in = 5'd0;
    logic [7:0] rep_cnt = 8'd0;
    logic       seq2, valid2, busy2, done2;
    logic       seq0, valid0, busy0, done0;
    logic [3:0] q2[$];
    logic [3:0] q0[$];
    int         n_run = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    seq_pattern_tx #(.PAT_W(5), .DEF_PATTERN(5'b11101), .GAP_CYC(2), .REP_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .use_custom(use_custom), .pat_in(pat_in), .rep_cnt(rep_cnt),
        .out_seq(seq2), .out_valid(valid2), .busy(busy2), .done(done2)
    );

    seq_pattern_tx #(.PAT_W(5), .DEF_PATTERN(5'b11101), .GAP_CYC(0), .REP_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .use_custom(use_custom), .pat_in(pat_in), .rep_cnt(rep_cnt),
        .out_seq(seq0), .out_valid(valid0), .busy(busy0), .done(done0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {busy, done, valid, seq} per cycle after the accepting edge.
    task automatic push_tx(input bit d0, input logic [4:0] p, input int reps);
        int g = d0 ? 0 : 2;
        int r = (reps == 0) ? 1 : reps;
        for (int i = 0; i < r; i++) begin
            for (int b = 4; b >= 0; b--)
                if (d0) q0.push_back({3'b101, p[b]}); else q2.push_back({3'b101, p[b]});
            if (i < r - 1)
                for (int k = 0; k < g; k++)
                    if (d0) q0.push_back(4'b1000); else q2.push_back(4'b1000);
        end
        if (d0) q0.push_back(4'b1100); else q2.push_back(4'b1100);
    endtask

    task automatic start_tx(input bit d0, input logic cust, input logic [4:0] p, input logic [7:0] r);
        use_custom = cust;
        pat_in     = p;
        rep_cnt    = r;
        push_tx(d0, cust ? p : 5'b11101, int'(r));
        if (d0) start0 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start0     = 1'b0;
        start2     = 1'b0;
        use_custom = ~cust;
        pat_in     = ~p;
        rep_cnt    = r + 8'd3;
    endtask

    task automatic drain();
        int n = 0;
        while ((q2.size() != 0 || q0.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain timeout", 32'(n < 200), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    always @(posedge clk) begin
        logic [3:0] e2, e0;
        #1;
        e2 = 4'b0;
        e0 = 4'b0;
        if (q2.size() != 0) e2 = q2.pop_front();
        if (q0.size() != 0) e0 = q0.pop_front();
        chk("gap2 stream", 32'({busy2, done2, valid2, seq2}), 32'(e2));
        chk("gap0 stream", 32'({busy0, done0, valid0, seq0}), 32'(e0));
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset outputs", 32'({busy2, done2, valid2, seq2, busy0, done0, valid0, seq0}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        start_tx(1'b0, 1'b0, 5'b00000, 8'd1);
        drain();
        start_tx(1'b0, 1'b1, 5'b10110, 8'd3);
        drain();
        start_tx(1'b0, 1'b0, 5'b01010, 8'd0);
        drain();
        start_tx(1'b1, 1'b0, 5'b00000, 8'd2);
        drain();
        start_tx(1'b1, 1'b1, 5'b10011, 8'd0);
        drain();
        // abort while bit 3 of repetition 1 is on the line
        start_tx(1'b0, 1'b1, 5'b10110, 8'd2);
        repeat (2) @(negedge clk);
        abort2 = 1'b1;
        q2.delete();
        @(negedge clk);
        abort2 = 1'b0;
        chk("abort busy", 32'(busy2), 32'd0);
        start_tx(1'b0, 1'b1, 5'b11001, 8'd1);
        drain();
        // start pulses during SEND and during DONE must be ignored
        start_tx(1'b0, 1'b1, 5'b10110, 8'd2);
        repeat (2) @(negedge clk);
        start2 = 1'b1;
        pat_in = 5'b01001;
        @(negedge clk);
        start2 = 1'b0;
        repeat (9) @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        drain();
        // asynchronous reset in the middle of a gap
        start_tx(1'b0, 1'b1, 5'b10110, 8'd2);
        repeat (5) @(negedge clk);
        chk("gap busy", 32'({busy2, valid2}), 32'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset", 32'({busy2, done2, valid2, seq2}), 32'd0);
        q2.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post reset busy", 32'(busy2), 32'd0);
        start_tx(1'b0, 1'b0, 5'b00000, 8'd1);
        drain();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
